// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with req/ready memory handshakes
// and a counted MULDIV wait state. Define CU_ILLEGAL_TRAP_EN to trap on undefined instructions.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W    = 4,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    output logic                  imem_req,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  rf_we,
    output logic                  sel_alu_b,
    output logic [1:0]            sel_wa,
    output logic [1:0]            sel_result,
    output logic [1:0]            sel_pc,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  muldiv_start,
    output logic                  illegal_op
);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MULDIV, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        K_ALU, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_MULDIV, K_ILL
    } kind_t;

    // Instruction class from opcode/funct; MFHI/MFLO are plain register writes.
    function automatic kind_t decode_kind(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h10, 6'h12, 6'h20, 6'h22,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: k = K_ALU;
                    6'h08:                             k = K_JR;
                    6'h19, 6'h1B:                      k = K_MULDIV;
                    default:                           k = K_ILL;
                endcase
            end
            6'h02:   k = K_J;
            6'h03:   k = K_JAL;
            6'h04:   k = K_BEQ;
            6'h08:   k = K_ADDI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] decode_alu(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] a;
        if (op == 6'h04) begin
            a = 4'd1;
        end else if (op == 6'h00) begin
            case (fn)
                6'h20:   a = 4'd2;
                6'h22:   a = 4'd3;
                6'h24:   a = 4'd4;
                6'h25:   a = 4'd5;
                6'h26:   a = 4'd6;
                6'h27:   a = 4'd7;
                6'h2A:   a = 4'd8;
                6'h00:   a = 4'd9;
                6'h02:   a = 4'd10;
                6'h08:   a = 4'd11;
                default: a = 4'd0;
            endcase
        end else begin
            a = 4'd0;
        end
        return a;
    endfunction

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [3:0] alu_q, alu_d;
    logic [7:0] cnt_q, cnt_d;
`ifdef CU_ILLEGAL_TRAP_EN
    logic       illegal_q, illegal_d;
`endif

    // State, decoded control word and MULDIV counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            kind_q    <= K_ALU;
            alu_q     <= 4'd0;
            cnt_q     <= 8'd0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            alu_q     <= alu_d;
            cnt_q     <= cnt_d;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next-state and strobes; handshake strobes depend on ready in the same cycle.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        alu_d        = alu_q;
        cnt_d        = cnt_q;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        sel_alu_b    = 1'b0;
        sel_wa       = 2'b00;
        sel_result   = 2'b00;
        sel_pc       = 2'b00;
        alu_ctrl     = {ALU_CTRL_W{1'b0}};
        muldiv_start = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                kind_d  = decode_kind(opcode, funct);
                alu_d   = decode_alu(opcode, funct);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_ctrl = ALU_CTRL_W'(alu_q);
                case (kind_q)
                    K_ALU:  state_d = S_WB;
                    K_ADDI: begin
                        sel_alu_b = 1'b1;
                        state_d   = S_WB;
                    end
                    K_LW, K_SW: begin
                        sel_alu_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    K_BEQ: begin
                        pc_we   = 1'b1;
                        sel_pc  = zero ? 2'b01 : 2'b00;
                        state_d = S_FETCH;
                    end
                    K_J: begin
                        pc_we   = 1'b1;
                        sel_pc  = 2'b10;
                        state_d = S_FETCH;
                    end
                    K_JAL: begin
                        pc_we      = 1'b1;
                        sel_pc     = 2'b10;
                        rf_we      = 1'b1;
                        sel_wa     = 2'b10;
                        sel_result = 2'b10;
                        state_d    = S_FETCH;
                    end
                    K_JR: begin
                        pc_we   = 1'b1;
                        sel_pc  = 2'b11;
                        state_d = S_FETCH;
                    end
                    K_MULDIV: begin
                        muldiv_start = 1'b1;
                        cnt_d        = 8'(MULDIV_CYCLES - 1);
                        state_d      = S_MULDIV;
                    end
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
`else
                        pc_we     = 1'b1;
                        state_d   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (kind_q == K_SW);
                if (dmem_ready) begin
                    if (kind_q == K_SW) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                case (kind_q)
                    K_LW: begin
                        sel_result = 2'b00;
                        sel_wa     = 2'b00;
                    end
                    K_ADDI: begin
                        sel_result = 2'b01;
                        sel_wa     = 2'b00;
                    end
                    default: begin
                        sel_result = 2'b01;
                        sel_wa     = 2'b01;
                    end
                endcase
            end
            S_MULDIV: begin
                if (cnt_q == 8'd0) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = S_MULDIV;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RST;
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule
